// File: rtl/time_set_ctrl_if.sv
// Key inputs and time-counter/display outputs of the time-setting controller.
interface time_set_ctrl_if;
    logic       mode_key;
    logic       inc_key;
    logic       hour_en;
    logic       min_en;
    logic [1:0] mode;
    logic       set_active;
    logic       blink_hour;
    logic       blink_min;

    modport master (
        output mode_key, inc_key,
        input  hour_en, min_en, mode, set_active, blink_hour, blink_min
    );

    modport slave (
        input  mode_key, inc_key,
        output hour_en, min_en, mode, set_active, blink_hour, blink_min
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting mode controller: RUN / SET_HOUR / SET_MIN sequencing,
// increment pulses with auto-repeat, inactivity timeout and blink flags.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT    = 30,
    parameter int unsigned REPEAT_DLY = 3,
    parameter int unsigned REPEAT_PER = 2
) (
    input  logic           clk_1hz,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_DLY     = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] C_PER     = CW'(REPEAT_PER);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mode_prev;
    logic          r_inc_prev;
    logic [CW-1:0] r_idle;
    logic [CW-1:0] r_hold;
    logic [CW-1:0] r_rep;
    logic [CW-1:0] w_idle_nxt;
    logic [CW-1:0] w_hold_nxt;
    logic [CW-1:0] w_rep_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
    logic          r_hour_en;
    logic          r_min_en;
    logic          r_set_active;
    logic          r_blink_hour;
    logic          r_blink_min;
    logic          w_pulse;
    logic          w_hour_en_nxt;
    logic          w_min_en_nxt;
    logic          w_mode_rise;
    logic          w_inc_rise;
    logic          w_any_key;

    assign w_mode_rise = bus.mode_key & ~r_mode_prev;
    assign w_inc_rise  = bus.inc_key & ~r_inc_prev;
    assign w_any_key   = bus.mode_key | bus.inc_key;

    // Next state, counters, increment pulse and blink flags.
    always_comb begin
        w_state_nxt   = r_state;
        w_idle_nxt    = '0;
        w_hold_nxt    = '0;
        w_rep_nxt     = '0;
        w_pulse       = 1'b0;
        w_phase_nxt   = 1'b0;
        w_hour_en_nxt = 1'b0;
        w_min_en_nxt  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mode_rise) begin
                    w_state_nxt = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (w_mode_rise) begin
                    // Mode change wins over any increment; repeat state dropped.
                    w_state_nxt = (r_state == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
                end else if (!w_any_key) begin
                    if (r_idle == C_TIMEOUT) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_idle_nxt = r_idle + CW'(1);
                    end
                end else if (w_inc_rise) begin
                    w_pulse = 1'b1;
                end else if (bus.inc_key) begin
                    if (r_hold != C_DLY) begin
                        w_hold_nxt = r_hold + CW'(1);
                        w_pulse    = (w_hold_nxt == C_DLY);
                    end else begin
                        w_hold_nxt = r_hold;
                        w_rep_nxt  = r_rep + CW'(1);
                        if (w_rep_nxt == C_PER) begin
                            w_pulse   = 1'b1;
                            w_rep_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if ((w_state_nxt != ST_RUN) && (w_state_nxt == r_state)) begin
            w_phase_nxt = ~r_phase;
        end
        w_hour_en_nxt = w_pulse & (r_state == ST_SET_HOUR);
        w_min_en_nxt  = w_pulse & (r_state == ST_SET_MIN);
    end

    // State, counters, key history and registered outputs.
    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_mode_prev  <= 1'b1;
            r_inc_prev   <= 1'b1;
            r_idle       <= '0;
            r_hold       <= '0;
            r_rep        <= '0;
            r_phase      <= 1'b0;
            r_hour_en    <= 1'b0;
            r_min_en     <= 1'b0;
            r_set_active <= 1'b0;
            r_blink_hour <= 1'b0;
            r_blink_min  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode_prev  <= bus.mode_key;
            r_inc_prev   <= bus.inc_key;
            r_idle       <= w_idle_nxt;
            r_hold       <= w_hold_nxt;
            r_rep        <= w_rep_nxt;
            r_phase      <= w_phase_nxt;
            r_hour_en    <= w_hour_en_nxt;
            r_min_en     <= w_min_en_nxt;
            r_set_active <= (w_state_nxt != ST_RUN);
            r_blink_hour <= (w_state_nxt == ST_SET_HOUR) & w_phase_nxt & ~w_hour_en_nxt;
            r_blink_min  <= (w_state_nxt == ST_SET_MIN) & w_phase_nxt & ~w_min_en_nxt;
        end
    end

    assign bus.mode       = r_state;
    assign bus.hour_en    = r_hour_en;
    assign bus.min_en     = r_min_en;
    assign bus.set_active = r_set_active;
    assign bus.blink_hour = r_blink_hour;
    assign bus.blink_min  = r_blink_min;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: behavioural model checked every cycle plus
// directed sequences with literal expectations.
module tb_time_set_ctrl;
    localparam int TIMEOUT    = 30;
    localparam int REPEAT_DLY = 3;
    localparam int REPEAT_PER = 2;

    logic clk_1hz = 1'b0;
    logic rst_n;
    int   checks  = 0;
    int   errors  = 0;
    bit   cmp_en  = 1'b0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .TIMEOUT    (TIMEOUT),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) dut (
        .clk_1hz (clk_1hz),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of key levels; returns at the next falling edge,
    // where the outputs caused by these keys are visible.
    task automatic cyc(input logic mk, input logic ik);
        bus.mode_key = mk;
        bus.inc_key  = ik;
        @(negedge clk_1hz);
    endtask

    // Model: state 0 RUN, 1 SET_HOUR, 2 SET_MIN; m_k counts cycles INC has
    // been held since its press (or since the state was entered).
    int m_state = 0;
    int m_k     = 0;
    int m_idle  = 0;
    int m_age   = 0;
    bit m_pm    = 1'b1;
    bit m_pi    = 1'b1;
    bit m_hour  = 1'b0;
    bit m_min   = 1'b0;
    bit m_bh    = 1'b0;
    bit m_bm    = 1'b0;

    always @(posedge clk_1hz or negedge rst_n) begin : model
        bit mk, ik, mr, ir, pulse, stay;
        int nxt;
        if (!rst_n) begin
            m_state = 0; m_k = 0; m_idle = 0; m_age = 0;
            m_pm = 1'b1; m_pi = 1'b1;
            m_hour = 1'b0; m_min = 1'b0; m_bh = 1'b0; m_bm = 1'b0;
        end else begin
            mk  = bus.mode_key;
            ik  = bus.inc_key;
            mr  = mk && !m_pm;
            ir  = ik && !m_pi;
            nxt = m_state;
            if (m_state == 0) begin
                if (mr) nxt = 1;
            end else if (mr) begin
                nxt = (m_state == 1) ? 2 : 0;
            end else if (!mk && !ik && m_idle == TIMEOUT) begin
                nxt = 0;
            end
            stay = (nxt == m_state) && (m_state != 0);

            if (!stay || mk || ik) m_idle = 0;
            else                   m_idle = m_idle + 1;

            if (!stay || ir || !ik) m_k = 0;
            else                    m_k = m_k + 1;

            pulse = stay && ik &&
                    (ir || (m_k >= REPEAT_DLY && ((m_k - REPEAT_DLY) % REPEAT_PER) == 0));

            m_age   = (nxt != m_state) ? 0 : m_age + 1;
            m_state = nxt;
            m_pm    = mk;
            m_pi    = ik;
            m_hour  = pulse && (nxt == 1);
            m_min   = pulse && (nxt == 2);
            m_bh    = (nxt == 1) && (m_age % 2 == 1) && !m_hour;
            m_bm    = (nxt == 2) && (m_age % 2 == 1) && !m_min;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_1hz) begin
        if (cmp_en && rst_n) begin
            check("mdl_mode",       int'(bus.mode),       m_state);
            check("mdl_set_active", int'(bus.set_active), int'(m_state != 0));
            check("mdl_hour_en",    int'(bus.hour_en),    int'(m_hour));
            check("mdl_min_en",     int'(bus.min_en),     int'(m_min));
            check("mdl_blink_hour", int'(bus.blink_hour), int'(m_bh));
            check("mdl_blink_min",  int'(bus.blink_min),  int'(m_bm));
            check("pulse_excl",     int'(bus.hour_en & bus.min_en), 0);
        end
    end

    initial begin : stim
        logic [5:0]  mseq;
        logic [3:0]  bseq;
        logic [11:0] burst;
        int          bh_other;
        int          min_cnt;
        int          n;

        rst_n        = 1'b0;
        bus.mode_key = 1'b1;
        bus.inc_key  = 1'b1;
        repeat (2) @(negedge clk_1hz);
        check("rst_mode",       int'(bus.mode),       0);
        check("rst_hour_en",    int'(bus.hour_en),    0);
        check("rst_min_en",     int'(bus.min_en),     0);
        check("rst_set_active", int'(bus.set_active), 0);
        check("rst_blink",      int'(bus.blink_hour | bus.blink_min), 0);

        // Keys held through reset release are not edges.
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cyc(1, 1);
        cyc(1, 1);
        check("held_mode",    int'(bus.mode),    0);
        check("held_hour_en", int'(bus.hour_en), 0);
        cyc(0, 0);
        cyc(1, 0);
        check("enter_hour_mode", int'(bus.mode),       1);
        check("enter_hour_act",  int'(bus.set_active), 1);
        cyc(0, 0);
        cyc(1, 0);
        check("to_min_mode", int'(bus.mode), 2);
        cyc(0, 0);
        cyc(1, 0);
        check("to_run_mode", int'(bus.mode),       0);
        check("to_run_act",  int'(bus.set_active), 0);
        cyc(0, 0);

        // Three presses from RUN, watching blink_hour between them.
        mseq     = '0;
        bseq     = '0;
        bh_other = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0);
            mseq = {mseq[3:0], bus.mode};
            for (int j = 0; j < 4; j++) begin
                cyc(0, 0);
                if (i == 0) bseq = {bseq[2:0], bus.blink_hour};
                else        bh_other = bh_other + int'(bus.blink_hour);
            end
        end
        check("mode_seq",     int'(mseq), 6'b01_10_00);
        check("blink_hr_seq", int'(bseq), 4'b1010);
        check("blink_hr_off", bh_other,   0);

        // Single INC press in SET_MIN, then in RUN.
        cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        cyc(0, 1);
        check("min_pulse",    int'(bus.min_en),  1);
        check("min_no_hour",  int'(bus.hour_en), 0);
        cyc(0, 0);
        check("min_one_shot", int'(bus.min_en),  0);
        cyc(1, 0); cyc(0, 0);
        check("back_run", int'(bus.mode), 0);
        cyc(0, 1);
        check("run_no_pulse", int'(bus.hour_en | bus.min_en), 0);
        cyc(0, 0);
        check("run_no_pulse2", int'(bus.hour_en | bus.min_en), 0);

        // Auto-repeat burst in SET_HOUR: INC held 10 cycles.
        cyc(1, 0); cyc(0, 0);
        burst   = '0;
        min_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            cyc(0, (j < 10) ? 1'b1 : 1'b0);
            burst[j] = bus.hour_en;
            min_cnt  = min_cnt + int'(bus.min_en);
        end
        check("burst_pattern", int'(burst), 12'h2A9);
        check("burst_count",   int'($countones(burst)), 5);
        check("burst_no_min",  min_cnt, 0);

        // Inactivity timeout from a fresh SET_HOUR entry.
        cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        cyc(1, 0);
        n = 0;
        while (bus.mode != 2'b00 && n < 60) begin
            cyc(0, 0);
            n++;
        end
        check("timeout_cycles", n, 31);

        // A key at idle = 29 restarts the count.
        cyc(1, 0);
        check("reenter_hour", int'(bus.mode), 1);
        repeat (29) cyc(0, 0);
        cyc(0, 1);
        check("late_key_mode",  int'(bus.mode),    1);
        check("late_key_pulse", int'(bus.hour_en), 1);
        n = 0;
        while (bus.mode != 2'b00 && n < 60) begin
            cyc(0, 0);
            n++;
        end
        check("timeout_restart", n, 31);

        // MODE and INC rising together in SET_HOUR.
        cyc(1, 0); cyc(0, 0);
        cyc(1, 1);
        check("simul_mode",     int'(bus.mode),    2);
        check("simul_no_hour",  int'(bus.hour_en), 0);
        check("simul_no_min",   int'(bus.min_en),  0);
        cyc(0, 0);

        // Reset asserted in the middle of an auto-repeat burst.
        cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        cyc(0, 1); cyc(0, 1); cyc(0, 1); cyc(0, 1);
        check("pre_rst_pulse", int'(bus.hour_en), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_hour",  int'(bus.hour_en),    0);
        check("mid_rst_mode",  int'(bus.mode),       0);
        check("mid_rst_act",   int'(bus.set_active), 0);
        check("mid_rst_blink", int'(bus.blink_hour), 0);
        bus.inc_key = 1'b0;
        @(negedge clk_1hz);
        rst_n = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        check("post_rst_mode", int'(bus.mode), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
